serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial, LSB-first subtractor computing diff = a - b over WIDTH cycles with a single borrow flip-flop. It is the inverse-operation counterpart to the team's ripple adder cells: an arithmetic back-end used where area matters more than latency. The start/busy/done handshake lets a controller issue one subtraction at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH; held until the next accepted start.
- borrow_out  output  1  final borrow, meaning a < b unsigned; held with diff.
- ovf  output  1  signed overflow; exists only with SERIAL_SUB_OVF_EN.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, diff, borrow_out, ovf and the borrow FF are all 0; bit counter is 0.
- States: IDLE, RUN, DONE.
  - IDLE→RUN: on start=1. The same edge loads shift regs sa<=a and sb<=b, clears borrow, sets cnt=0, and clears diff.
  - RUN, per cycle: cell inputs are sa[0], sb[0], borrow.
    - d = sa[0] ^ sb[0] ^ borrow.
    - bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow).
    - diff shifts right with d entering the MSB; sa and sb shift right; borrow <= bout; cnt++.
  - RUN→DONE: on the edge where cnt == WIDTH-1. That edge writes the final diff bit and sets borrow_out <= bout.
  - DONE: done=1 for exactly one cycle, then DONE→IDLE unconditionally.
- Latency: start sampled at edge T; RUN occupies cycles T+1..T+WIDTH; done is high in cycle T+WIDTH+1; the next start is accepted at the end of that cycle's successor (IDLE).
- start while busy=1 (RUN or DONE) is ignored, with no queuing. Operands presented with an ignored start have no effect.
- a and b may change freely after the accepting edge.
- diff and borrow_out remain stable from done until the edge that accepts the next start.
- rst mid-RUN: immediate return to IDLE with all outputs 0; the partial result is discarded.
- cnt width is $clog2(WIDTH). There is no wrap beyond WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - The ovf port exists. On the final RUN edge, ovf <= (a_msb ^ b_msb) & (a_msb ^ d_msb), using the MSBs processed in the last bit-cycle. The MSBs of a and b are retained in dedicated flops at accept.
  - ovf is cleared on accept and held with diff.
- Undefined: the port and its flops are absent, and all other behaviour is identical.

Decomposition:
- Package serial_arith_pkg holds:
  - the state enum typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - localparam function/constant for the counter width.
- Sub-module: full_subtractor_cell. It is purely combinational: inputs x, y, bin; outputs d, bout. It is the dual of the existing full-adder cell and is instantiated once.

Test Plan (WIDTH=8):
- a=0x5A, b=0x23, start pulse → done exactly 9 cycles after the accepting edge; diff=0x37, borrow_out=0.
- a=0x10, b=0x20 → diff=0xF0, borrow_out=1. Edge operands: a=0x00, b=0x00 → diff=0x00, borrow_out=0; a=0x00, b=0xFF → diff=0x01, borrow_out=1.
- start with a=0x05, b=0x03; at RUN cycle 3 assert start with a=0xFF, b=0x00 → ignored; result diff=0x02; exactly one done pulse.
- Back-to-back: re-assert start each cycle → second accept in the IDLE cycle after done; both results correct; busy low for exactly that one cycle.
- rst asserted asynchronously mid-RUN (cycle 4) → all outputs 0 immediately. The next start with a=0x09, b=0x04 → diff=0x05.
- SERIAL_SUB_OVF_EN defined: a=0x80, b=0x01 → diff=0x7F, ovf=1. a=0x7F, b=0xFF → diff=0x80, ovf=1. a=0x40, b=0x10 → ovf=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg
//   Shared types and helpers for the bit-serial arithmetic back-ends.
//   - sub_state_e : controller states of the serial subtractor
//   - cnt_width() : bit-counter width for a given operand width
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_e;

   // Counter only has to reach w-1, so $clog2(w) bits suffice (w >= 2).
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell
//   One-bit combinational full subtractor: x - y - bin.
//   Ports:
//     x, y, bin : minuend bit, subtrahend bit, borrow in
//     d         : difference bit
//     bout      : borrow out
module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   // Borrow when x<y outright, or when x==y and a borrow is already pending.
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first subtractor: diff = a - b over WIDTH cycles using
//   a single borrow flop and one full_subtractor_cell.
//   Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
//   Ports:
//     clk, rst    : clock (rising edge), asynchronous active-high reset
//     start       : request, sampled only in IDLE
//     a, b        : minuend / subtrahend, captured on the accepting edge
//     busy        : high in RUN and DONE
//     done        : one-cycle pulse, result valid
//     diff        : a - b mod 2^WIDTH, held until the next accepted start
//     borrow_out  : final borrow (a < b unsigned), held with diff
//     ovf         : signed overflow (SERIAL_SUB_OVF_EN only), held with diff
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             borrow_out,
   output logic             ovf
`else
   output logic             borrow_out
`endif
);

   localparam int CW = cnt_width(WIDTH);

   sub_state_e       state, nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sa, sb;
   logic             brw;
   logic             cell_d, cell_bout;
   logic             last;

   full_subtractor_cell u_cell (
      .x    (sa[0]),
      .y    (sb[0]),
      .bin  (brw),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign last = (cnt == CW'(WIDTH - 1));

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt  = state;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         IDLE: if (start) nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) nxt = DONE;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa         <= '0;
         sb         <= '0;
         brw        <= 1'b0;
         cnt        <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               sa         <= a;
               sb         <= b;
               brw        <= 1'b0;
               cnt        <= '0;
               diff       <= '0;
               borrow_out <= 1'b0;
            end
            RUN: begin
               // Result bits enter at the MSB so bit 0 lands in diff[0] after WIDTH shifts.
               diff <= {cell_d, diff[WIDTH-1:1]};
               sa   <= sa >> 1;
               sb   <= sb >> 1;
               brw  <= cell_bout;
               if (last) borrow_out <= cell_bout;
               else      cnt        <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Operand sign bits kept separately so overflow does not depend on
   // what is left in the shift registers at the final bit-cycle.
   logic a_msb, b_msb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            ovf   <= 1'b0;
         end else if (state == RUN && last) begin
            // Overflow: operand signs differ and result sign differs from a.
            ovf <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
         end
      end
   end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [W-1:0] a, b, diff;
   logic         busy, done, borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
      .borrow_out (borrow_out),
      .ovf        (ovf)
`else
      .borrow_out (borrow_out)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         ov;
      int           cyc;
   } exp_t;

   exp_t         q[$];
   int           checks = 0, errors = 0;
   int           cyc = 0;
   int           left = 0;
   int           ndone = 0;
   logic [W-1:0] held_d = '0;
   logic         held_b = 1'b0, held_o = 1'b0;

   // Reference: plain unsigned/signed arithmetic.
   function automatic exp_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input int c);
      exp_t e;
      int   sx, sy, sd;
      e.d = x - y;
      e.br = (x < y);
      sx = $signed(x);
      sy = $signed(y);
      sd = sx - sy;
      e.ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
      e.cyc = c;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Transaction model: a start is taken only when no operation is pending;
   // it then occupies WIDTH run cycles plus one done cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         left <= 0;
      end else begin
         cyc <= cyc + 1;
         if (left == 0 && start === 1'b1) begin
            // done appears WIDTH edges after this accepting edge.
            q.push_back(ref_sub(a, b, cyc + W + 1));
            left <= W + 1;
         end else if (left > 0) begin
            left <= left - 1;
         end
      end
   end

   // Monitor: pops an expectation whenever the DUT signals done.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         held_d = '0;
         held_b = 1'b0;
         held_o = 1'b0;
      end else begin
         chk("busy", busy, left != 0);
         chk("done", done, left == 1);
         if (done) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 expected=0 t=%0t", $time);
            end else begin
               e = q.pop_front();
               chk("latency", cyc, e.cyc);
               chk("diff", diff, e.d);
               chk("borrow_out", borrow_out, e.br);
`ifdef SERIAL_SUB_OVF_EN
               chk("ovf", ovf, e.ov);
`endif
               held_d = e.d;
               held_b = e.br;
               held_o = e.ov;
               ndone++;
            end
         end else if (left == 0) begin
            chk("hold_diff", diff, held_d);
            chk("hold_borrow", borrow_out, held_b);
`ifdef SERIAL_SUB_OVF_EN
            chk("hold_ovf", ovf, held_o);
`endif
         end
      end
   end

   // Waits (bounded) until the model is idle, scrambling operands meanwhile.
   task automatic wait_idle();
      int n = 0;
      while (left != 0 && n < 100) begin
         @(negedge clk);
         a = W'($urandom);
         b = W'($urandom);
         n++;
      end
      if (left != 0) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=%0d expected=0", left);
      end
   endtask

   // Call just after a negedge with the model idle.
   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1;
      a = x;
      b = y;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      wait_idle();
   endtask

   initial begin
      int n0;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_diff", diff, '0);
      chk("rst_borrow", borrow_out, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      chk("rst_ovf", ovf, 1'b0);
`endif
      rst = 1'b0;

      op(8'h5A, 8'h23);
      chk("plan_5a_23", diff, 8'h37);
      chk("plan_5a_23_br", borrow_out, 1'b0);
      op(8'h10, 8'h20);
      chk("plan_10_20", diff, 8'hF0);
      chk("plan_10_20_br", borrow_out, 1'b1);
      op(8'h00, 8'h00);
      chk("plan_00_00", diff, 8'h00);
      op(8'h00, 8'hFF);
      chk("plan_00_ff", diff, 8'h01);
      chk("plan_00_ff_br", borrow_out, 1'b1);

      // Start during RUN must be ignored.
      n0 = ndone;
      start = 1'b1;
      a = 8'h05;
      b = 8'h03;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      a = 8'hFF;
      b = 8'h00;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      chk("ignored_start", diff, 8'h02);
      chk("ignored_one_done", ndone - n0, 1);

      // Back-to-back: start held high across two full operations.
      n0 = ndone;
      start = 1'b1;
      for (int i = 0; i < W + 3; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      wait_idle();
      chk("b2b_dones", ndone - n0, 2);

      // Asynchronous reset mid-RUN.
      start = 1'b1;
      a = 8'hC3;
      b = 8'h5E;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_diff", diff, '0);
      chk("midrst_borrow", borrow_out, 1'b0);
      @(negedge clk);
      #1 rst = 1'b0;
      op(8'h09, 8'h04);
      chk("after_rst", diff, 8'h05);

`ifdef SERIAL_SUB_OVF_EN
      op(8'h80, 8'h01);
      chk("ovf_80_01", ovf, 1'b1);
      chk("ovf_80_01_d", diff, 8'h7F);
      op(8'h7F, 8'hFF);
      chk("ovf_7f_ff", ovf, 1'b1);
      chk("ovf_7f_ff_d", diff, 8'h80);
      op(8'h40, 8'h10);
      chk("ovf_40_10", ovf, 1'b0);
`endif

      // Random traffic with sporadic starts.
      repeat (400) begin
         start = ($urandom_range(0, 2) == 0);
         a = W'($urandom);
         b = W'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      wait_idle();
      @(negedge clk);
      chk("drain", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
